combat_resolver: RTL and testbench

Frame-rate combat referee sitting directly downstream of the two `player` instances: each game frame it compares each player's attack hitbox against the opponent's hurtbox, applies damage and hitstun, and tracks the round state. Its health, hitstun and round outputs feed back into the player FSMs and into the top-level colour mux for HUD drawing. One clock edge equals one game frame; in the top level it runs on the same `effective_clk` as the players.

---
 rtl/combat_resolver.sv | 199 +++++++++++++++++++
 tb/tb_combat_resolver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/combat_resolver.sv
// combat_resolver: per-frame hitbox/hurtbox referee tracking health, hitstun and round state.
// Optional blocking (chip damage, no stun) is compiled in when COMBAT_BLOCK_EN is defined.
module combat_resolver #(
    parameter int HP_MAX      = 100,
    parameter int DAMAGE      = 10,
    parameter int STUN_FRAMES = 15,
    parameter int KO_FRAMES   = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       p1_hit_active,
    input  logic [9:0] p1_hit_x1,
    input  logic [9:0] p1_hit_x2,
    input  logic [9:0] p1_hit_y1,
    input  logic [9:0] p1_hit_y2,
    input  logic       p2_hit_active,
    input  logic [9:0] p2_hit_x1,
    input  logic [9:0] p2_hit_x2,
    input  logic [9:0] p2_hit_y1,
    input  logic [9:0] p2_hit_y2,
    input  logic [9:0] p1_hurt_x1,
    input  logic [9:0] p1_hurt_x2,
    input  logic [9:0] p1_hurt_y1,
    input  logic [9:0] p1_hurt_y2,
    input  logic [9:0] p2_hurt_x1,
    input  logic [9:0] p2_hurt_x2,
    input  logic [9:0] p2_hurt_y1,
    input  logic [9:0] p2_hurt_y2,
`ifdef COMBAT_BLOCK_EN
    input  logic       p1_block,
    input  logic       p2_block,
`endif
    output logic [6:0] p1_health,
    output logic [6:0] p2_health,
    output logic       p1_stun,
    output logic       p2_stun,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic       round_active,
    output logic [1:0] winner
);

    localparam int STUN_W = $clog2(STUN_FRAMES + 1);
    localparam int KO_W   = $clog2(KO_FRAMES + 1);

    localparam logic [6:0]        HP_INIT   = 7'(HP_MAX);
    localparam logic [6:0]        FULL_DMG  = 7'(DAMAGE);
    localparam logic [6:0]        BLOCK_DMG = 7'(DAMAGE >> 2);
    localparam logic [STUN_W-1:0] STUN_LOAD = STUN_W'(STUN_FRAMES);
    localparam logic [KO_W-1:0]   KO_LAST   = KO_W'(KO_FRAMES - 1);

    typedef enum logic [1:0] {
        FIGHT = 2'd0,
        KO    = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [STUN_W-1:0] p1_stun_cnt;
    logic [STUN_W-1:0] p2_stun_cnt;
    logic [KO_W-1:0]   ko_cnt;
    logic              p1_latch;
    logic              p2_latch;

    logic       p1_blocked;
    logic       p2_blocked;
    logic       hit_on_p1;
    logic       hit_on_p2;
    logic [6:0] next_p1_health;
    logic [6:0] next_p2_health;
    logic       ko_now;
    logic       do_restart;

    // Degenerate boxes are rejected explicitly; the bare strict test would accept some of them.
    function automatic logic boxes_overlap(
        input logic [9:0] ax1, input logic [9:0] ax2, input logic [9:0] ay1, input logic [9:0] ay2,
        input logic [9:0] bx1, input logic [9:0] bx2, input logic [9:0] by1, input logic [9:0] by2
    );
        return (ax1 < ax2) && (ay1 < ay2) && (bx1 < bx2) && (by1 < by2) &&
               (ax1 < bx2) && (bx1 < ax2) && (ay1 < by2) && (by1 < ay2);
    endfunction

    function automatic logic [6:0] sat_sub(input logic [6:0] health, input logic [6:0] dmg);
        return (health > dmg) ? (health - dmg) : 7'd0;
    endfunction

`ifdef COMBAT_BLOCK_EN
    assign p1_blocked = p1_block;
    assign p2_blocked = p2_block;
`else
    assign p1_blocked = 1'b0;
    assign p2_blocked = 1'b0;
`endif

    always_comb begin
        hit_on_p2 = (state == FIGHT) && p1_hit_active && !p1_latch && (p2_stun_cnt == '0) &&
                    boxes_overlap(p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
                                  p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
        hit_on_p1 = (state == FIGHT) && p2_hit_active && !p2_latch && (p1_stun_cnt == '0) &&
                    boxes_overlap(p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
                                  p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);

        next_p1_health = p1_health;
        next_p2_health = p2_health;
        if (hit_on_p1) begin
            next_p1_health = sat_sub(p1_health, p1_blocked ? BLOCK_DMG : FULL_DMG);
        end
        if (hit_on_p2) begin
            next_p2_health = sat_sub(p2_health, p2_blocked ? BLOCK_DMG : FULL_DMG);
        end

        ko_now     = (state == FIGHT) && ((next_p1_health == 7'd0) || (next_p2_health == 7'd0));
        do_restart = (state == WAIT) && restart;
    end

    always_comb begin
        next_state = state;
        case (state)
            FIGHT:   if (ko_now) next_state = KO;
            KO:      if (ko_cnt == KO_LAST) next_state = WAIT;
            WAIT:    if (restart) next_state = FIGHT;
            default: next_state = FIGHT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FIGHT;
        end else begin
            state <= next_state;
        end
    end

    // Health, stun, latches and winner all move on the same edge as the state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_health   <= HP_INIT;
            p2_health   <= HP_INIT;
            p1_stun_cnt <= '0;
            p2_stun_cnt <= '0;
            p1_latch    <= 1'b0;
            p2_latch    <= 1'b0;
            p1_hit      <= 1'b0;
            p2_hit      <= 1'b0;
            winner      <= 2'b00;
            ko_cnt      <= '0;
        end else begin
            p1_hit <= hit_on_p1;
            p2_hit <= hit_on_p2;
            ko_cnt <= (state == KO) ? ko_cnt + KO_W'(1) : '0;
            if (do_restart) begin
                p1_health   <= HP_INIT;
                p2_health   <= HP_INIT;
                p1_stun_cnt <= '0;
                p2_stun_cnt <= '0;
                p1_latch    <= 1'b0;
                p2_latch    <= 1'b0;
                winner      <= 2'b00;
            end else begin
                p1_health <= next_p1_health;
                p2_health <= next_p2_health;

                if (hit_on_p1 && !p1_blocked) begin
                    p1_stun_cnt <= STUN_LOAD;
                end else if (p1_stun_cnt != '0) begin
                    p1_stun_cnt <= p1_stun_cnt - STUN_W'(1);
                end
                if (hit_on_p2 && !p2_blocked) begin
                    p2_stun_cnt <= STUN_LOAD;
                end else if (p2_stun_cnt != '0) begin
                    p2_stun_cnt <= p2_stun_cnt - STUN_W'(1);
                end

                if (!p1_hit_active) begin
                    p1_latch <= 1'b0;
                end else if (hit_on_p2) begin
                    p1_latch <= 1'b1;
                end
                if (!p2_hit_active) begin
                    p2_latch <= 1'b0;
                end else if (hit_on_p1) begin
                    p2_latch <= 1'b1;
                end

                if (ko_now) begin
                    winner <= {next_p1_health == 7'd0, next_p2_health == 7'd0};
                end
            end
        end
    end

    assign p1_stun      = (p1_stun_cnt != '0);
    assign p2_stun      = (p2_stun_cnt != '0);
    assign round_active = (state == FIGHT);

endmodule

// File: tb/tb_combat_resolver.sv
// tb_combat_resolver: directed frames push expected outputs into a queue; a monitor pops
// each entry on the falling edge of the frame it belongs to and compares it against the DUT.
module tb_combat_resolver;

    logic       clk;
    logic       rst;
    logic       restart;
    logic       p1_hit_active, p2_hit_active;
    logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
    logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
    logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
`ifdef COMBAT_BLOCK_EN
    logic       p1_block, p2_block;
`endif
    logic [6:0] p1_health, p2_health;
    logic       p1_stun, p2_stun, p1_hit, p2_hit, round_active;
    logic [1:0] winner;

    combat_resolver dut (
        .clk(clk), .rst(rst), .restart(restart),
        .p1_hit_active(p1_hit_active),
        .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2), .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
        .p2_hit_active(p2_hit_active),
        .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2), .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
        .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2), .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
        .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2), .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
`ifdef COMBAT_BLOCK_EN
        .p1_block(p1_block), .p2_block(p2_block),
`endif
        .p1_health(p1_health), .p2_health(p2_health),
        .p1_stun(p1_stun), .p2_stun(p2_stun),
        .p1_hit(p1_hit), .p2_hit(p2_hit),
        .round_active(round_active), .winner(winner)
    );

    typedef struct {
        int         frame;
        string      name;
        logic [6:0] h1;
        logic [6:0] h2;
        logic       s1, s2, k1, k2, ra;
        logic [1:0] w;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   frame = 0;
    int   total = 0;
    int   bad   = 0;
    int   ko_frame;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) frame <= frame + 1;

    // Monitor: each expectation is tagged with the frame whose outputs it describes.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            if (exp_q[0].frame < frame) begin
                mon_e = exp_q.pop_front();
                total++;
                bad++;
                $display("[TB] FAIL %s: expectation for frame %0d never compared (now %0d)",
                         mon_e.name, mon_e.frame, frame);
            end else if (exp_q[0].frame == frame) begin
                mon_e = exp_q.pop_front();
                total++;
                if ({p1_health, p2_health, p1_stun, p2_stun, p1_hit, p2_hit, round_active, winner} !==
                    {mon_e.h1, mon_e.h2, mon_e.s1, mon_e.s2, mon_e.k1, mon_e.k2, mon_e.ra, mon_e.w}) begin
                    bad++;
                    $display("[TB] FAIL %s frame=%0d got h1=%0d h2=%0d stun=%b%b hit=%b%b ra=%b win=%b want h1=%0d h2=%0d stun=%b%b hit=%b%b ra=%b win=%b",
                             mon_e.name, frame, p1_health, p2_health, p1_stun, p2_stun, p1_hit, p2_hit,
                             round_active, winner, mon_e.h1, mon_e.h2, mon_e.s1, mon_e.s2,
                             mon_e.k1, mon_e.k2, mon_e.ra, mon_e.w);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, frame=%0d", frame);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_at(input int f, input string name, input int h1, input int h2,
                           input logic s1, input logic s2, input logic k1, input logic k2,
                           input logic ra, input logic [1:0] w);
        exp_t e;
        e.frame = f;
        e.name  = name;
        e.h1    = 7'(h1);
        e.h2    = 7'(h2);
        e.s1    = s1;
        e.s2    = s2;
        e.k1    = k1;
        e.k2    = k2;
        e.ra    = ra;
        e.w     = w;
        exp_q.push_back(e);
    endtask

    // Issue the current inputs for one frame, expecting the given outputs after the edge.
    task automatic step(input string name, input int h1, input int h2,
                        input logic s1, input logic s2, input logic k1, input logic k2,
                        input logic ra, input logic [1:0] w);
        push_at(frame + 1, name, h1, h2, s1, s2, k1, k2, ra, w);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        restart = 1'b0;
        p1_hit_active = 1'b0;
        p2_hit_active = 1'b0;
        p1_hit_x1 = 10'd100; p1_hit_x2 = 10'd150; p1_hit_y1 = 10'd200; p1_hit_y2 = 10'd250;
        p2_hit_x1 = 10'd10;  p2_hit_x2 = 10'd60;  p2_hit_y1 = 10'd10;  p2_hit_y2 = 10'd60;
        p1_hurt_x1 = 10'd0;   p1_hurt_x2 = 10'd50;  p1_hurt_y1 = 10'd0;   p1_hurt_y2 = 10'd50;
        p2_hurt_x1 = 10'd140; p2_hurt_x2 = 10'd200; p2_hurt_y1 = 10'd200; p2_hurt_y2 = 10'd300;
`ifdef COMBAT_BLOCK_EN
        p1_block = 1'b0;
        p2_block = 1'b0;
`endif
        #2 rst = 1'b0;
        tick();
        push_at(frame, "reset", 100, 100, 0, 0, 0, 0, 1, 2'b00);
        tick();
        rst = 1'b1;

        // One hit per held attack; stun lasts exactly 15 frames.
        p1_hit_active = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step("hold", 100, 90, 0, (i <= 15), 0, (i == 1), 1, 2'b00);
        end
        p1_hit_active = 1'b0;
        step("drop", 100, 90, 0, 0, 0, 0, 1, 2'b00);
        p1_hit_active = 1'b1;
        step("rehit", 100, 80, 0, 1, 0, 1, 1, 2'b00);
        p1_hit_active = 1'b0;
        step("drop2", 100, 80, 0, 1, 0, 0, 1, 2'b00);

        // Fresh attack during stun is refused until the counter reaches zero.
        p1_hit_active = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            step("stun_gate", 100, (j == 15) ? 70 : 80, 0, (j <= 13) || (j == 15), 0, (j == 15), 1, 2'b00);
        end
        p1_hit_active = 1'b0;
        idle(17);

        // Boundary boxes: touching edges and a zero-width box.
        p1_hit_active = 1'b1;
        p1_hit_x2 = 10'd140;
        step("touch_x", 100, 70, 0, 0, 0, 0, 1, 2'b00);
        p1_hit_x1 = 10'd150; p1_hit_x2 = 10'd150;
        step("zero_width", 100, 70, 0, 0, 0, 0, 1, 2'b00);
        p1_hit_x1 = 10'd100; p1_hit_x2 = 10'd150; p1_hit_y1 = 10'd150; p1_hit_y2 = 10'd200;
        step("touch_y", 100, 70, 0, 0, 0, 0, 1, 2'b00);
        p1_hit_y1 = 10'd200; p1_hit_y2 = 10'd250;
        p1_hit_active = 1'b0;
        idle(1);

        p1_hit_active = 1'b1;
        p2_hit_active = 1'b1;
        step("trade", 90, 60, 1, 1, 1, 1, 1, 2'b00);
        p1_hit_active = 1'b0;
        p2_hit_active = 1'b0;

        for (int n = 1; n <= 6; n++) begin
            idle(17);
            p1_hit_active = 1'b1;
            step("ko_run", 90, 60 - 10 * n, 0, 1, 0, 1, (n == 6) ? 1'b0 : 1'b1, (n == 6) ? 2'b01 : 2'b00);
            p1_hit_active = 1'b0;
        end
        ko_frame = frame;

        idle(20);
        p1_hit_active = 1'b1;
        p2_hit_active = 1'b1;
        restart = 1'b1;
        step("ko_ignore", 90, 0, 0, 0, 0, 0, 0, 2'b01);
        p1_hit_active = 1'b0;
        p2_hit_active = 1'b0;
        restart = 1'b0;
        while (frame < ko_frame + 119) tick();
        restart = 1'b1;
        step("ko_length", 90, 0, 0, 0, 0, 0, 0, 2'b01);
        step("restart", 100, 100, 0, 0, 0, 0, 1, 2'b00);
        restart = 1'b0;

        for (int n = 1; n <= 10; n++) begin
            idle(17);
            p1_hit_active = 1'b1;
            step("ko_run2", 100, 100 - 10 * n, 0, 1, 0, 1, (n == 10) ? 1'b0 : 1'b1, (n == 10) ? 2'b01 : 2'b00);
            p1_hit_active = 1'b0;
        end

        // Reset pulled between edges must act before the next clock.
        idle(5);
        rst = 1'b0;
        push_at(frame, "async_rst", 100, 100, 0, 0, 0, 0, 1, 2'b00);
        tick();
        rst = 1'b1;
        p1_hit_active = 1'b1;
        step("post_rst", 100, 90, 0, 1, 0, 1, 1, 2'b00);
        p1_hit_active = 1'b0;

`ifdef COMBAT_BLOCK_EN
        idle(17);
        p2_block = 1'b1;
        p1_hit_active = 1'b1;
        step("block", 100, 88, 0, 0, 0, 1, 1, 2'b00);
        p1_hit_active = 1'b0;
        p2_block = 1'b0;
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
